gstdmasnd: RTL and testbench
============================

Name: gstdmasnd

Overview:
STE DMA sound frame sequencer; sits directly upstream of the shifter's audio FIFO. Holds the CPU-visible frame start/end/counter registers ($FF8900-$FF8913), arbitrates sound fetches against the shifter's SREQ and the MCU's sound DMA slot, and drives the RAM address plus the SLOAD_N strobe that writes MDIN into the FIFO. Signals frame end to the MFP (timer A event and GPIP7 activity level).

Parameters:
ADDR_W, 23, word address width (byte address bits [23:1]).
LOAD_LOW, 4, clk32 cycles SLOAD_N is held low per fetch (>=2).

Ports:
clk32  in  1  system clock
res  in  1  asynchronous reset, active-high
CS  in  1  sound register select (word offsets $00-$09)
A  in  6  register word offset, A[6:1] of CPU address
RW  in  1  1=read, 0=write
DIN  in  16  CPU write data
DOUT  out  16  CPU read data; 0 when not selected
SREQ  in  1  shifter FIFO not full
SLOT  in  1  one-cycle strobe: MCU grants sound DMA memory cycle
SADDR  out  ADDR_W  word address of current fetch
SLOAD_N  out  1  low during fetch; shifter latches MDIN on falling edge
SACTIVE  out  1  frame playing (MFP GPIP7 source)
SFRAME_END  out  1  one-cycle pulse at end of each frame (MFP timer A event)

Behaviour:
- Registers (word offset: content, low byte only, high byte reads 0):
  $00 control: bit0 ENA, bit1 LOOP; others read 0.
  $01/$02/$03 start hi[5:0]/mid[7:0]/lo[7:1]; lo bit0 reads 0.
  $04/$05/$06 counter hi/mid/lo: read-only current address; writes ignored.
  $07/$08/$09 end hi/mid/lo; same format as start.
- Writes take effect on the first clk32 with CS & ~RW after a cycle with ~CS (one write per access). Reads are combinational from registers.
- Start/end writes update programmed regs only; shadow copies (cur_start, cur_end) are loaded at frame start, so mid-frame writes take effect next frame.
- FSM states: IDLE, ARM, WAIT, LOAD, STEP.
  IDLE: SACTIVE=0, SLOAD_N=1. ENA written 0->1 -> ARM.
  ARM (1 cycle): counter<=start, cur_end<=end, SACTIVE=1. If start>=end (empty/bad frame) -> pulse SFRAME_END, then LOOP?ARM:IDLE with ENA cleared; else -> WAIT.
  WAIT: SADDR=counter. SLOT & SREQ in same cycle -> LOAD. SREQ low or missed slot -> stay.
  LOAD: SLOAD_N low exactly LOAD_LOW cycles, SADDR stable throughout -> STEP.
  STEP (1 cycle): counter<=counter+1 word. If new counter==cur_end: SFRAME_END pulse; LOOP=1 -> ARM (reload from programmed start/end), LOOP=0 -> clear ENA, IDLE. Else -> WAIT.
- Counter arithmetic: ADDR_W-bit, wraps at max to 0 silently; comparison is equality against cur_end.
- CPU writes ENA=0 in any state: abort at next clock. If in LOAD, SLOAD_N returns high immediately (shortened strobe tolerated; shifter already latched on falling edge). No SFRAME_END on abort. -> IDLE, SACTIVE=0.
- Writing ENA=1 while already playing: no restart; only LOOP bit updated.
- Clearing LOOP mid-frame: current frame finishes, then stops.
- SFRAME_END and control write same cycle: CPU write to ENA wins (ENA=1 re-arm when stopping on frame end -> ARM).
- Reset (any time, incl. mid-LOAD): all regs 0, state IDLE, SLOAD_N=1, SACTIVE=0, SFRAME_END=0, SADDR=0, DOUT=0.

Decomposition:
- Shared package: register offset constants ($00-$09), control bit indices, FSM state enum, ADDR_W default.
- One natural sub-module: gstdmasnd_regs (CPU register file, write-edge detect, read mux, shadow load); FSM and counter stay in top.

Test Plan:
- Reset during LOAD with SLOAD_N low -> SLOAD_N=1, SACTIVE=0, all regs read 0 in same/next cycle.
- start=$010000, end=$010008, LOOP=0, ENA=1, SREQ=1, SLOT every 8 cycles -> 4 fetches at word addr $8000,$8001,$8002,$8003, each SLOAD_N low 4 cycles; one SFRAME_END; ENA reads 0; SACTIVE falls.
- Same frame with LOOP=1; write end=$010004 mid-frame -> first frame 4 fetches, second frame 2 fetches from $8000; SFRAME_END twice; SACTIVE stays 1.
- SREQ=0 for 50 cycles while SLOT pulses -> no SLOAD_N; SREQ=1 -> fetch on next SLOT; counter reads advance by 2 bytes per fetch.
- start=end=$020000, ENA=1 -> no fetch, SFRAME_END once, back to IDLE.
- ENA=0 written during WAIT after 2 fetches -> no further SLOAD_N, no SFRAME_END, counter reads $010004.

Source files
------------

// File: rtl/gstdmasnd_pkg.sv
// Shared definitions for the STE DMA sound frame sequencer:
// register map, control bits, FSM states and address-field helpers.
package gstdmasnd_pkg;

  localparam int ADDR_W_DEF = 23;
  // Word-address bits covered by the hi[5:0]/mid[7:0]/lo[7:1] byte registers
  localparam int FIELD_W    = 21;

  localparam logic [5:0] OFS_CTRL      = 6'h00;
  localparam logic [5:0] OFS_START_HI  = 6'h01;
  localparam logic [5:0] OFS_START_MID = 6'h02;
  localparam logic [5:0] OFS_START_LO  = 6'h03;
  localparam logic [5:0] OFS_CNT_HI    = 6'h04;
  localparam logic [5:0] OFS_CNT_MID   = 6'h05;
  localparam logic [5:0] OFS_CNT_LO    = 6'h06;
  localparam logic [5:0] OFS_END_HI    = 6'h07;
  localparam logic [5:0] OFS_END_MID   = 6'h08;
  localparam logic [5:0] OFS_END_LO    = 6'h09;

  localparam int BIT_ENA  = 0;
  localparam int BIT_LOOP = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_LOAD,
    S_STEP
  } state_t;

  // CPU view of a word address: sel 0=hi, 1=mid, 2=lo (byte bit0 reads 0)
  function automatic logic [7:0] field_byte(input logic [FIELD_W-1:0] w,
                                            input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = {2'b00, w[20:15]};
      2'd1:    b = w[14:7];
      default: b = {w[6:0], 1'b0};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gstdmasnd_regs.sv
// CPU-visible sound register file: one-write-per-access strobe, control bits,
// programmed start/end addresses, end-address shadow and read mux.
module gstdmasnd_regs
  import gstdmasnd_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk32,
  input  logic               res,
  input  logic               CS,
  input  logic [5:0]         A,
  input  logic               RW,
  input  logic [15:0]        DIN,
  output logic [15:0]        DOUT,
  input  logic [FIELD_W-1:0] counter,
  input  logic               shadow_load,
  input  logic               ena_clr,
  output logic               ctrl_wr,
  output logic               loop,
  output logic [ADDR_W-1:0]  start_word,
  output logic [ADDR_W-1:0]  end_word,
  output logic [ADDR_W-1:0]  cur_end
);

  logic               cs_prev_reg;
  logic               wr_stb;
  logic               ena_reg;
  logic               loop_reg;
  logic [FIELD_W-1:0] cur_end_reg;
  logic [FIELD_W-1:0] frame_word [2];
  logic [7:0]         rd_byte;
  logic               unused_din;

  assign unused_din = ^DIN[15:8];

  // Only the first clock of a CS assertion writes
  assign wr_stb  = CS & ~RW & ~cs_prev_reg;
  assign ctrl_wr = wr_stb & (A == OFS_CTRL);

  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      cs_prev_reg <= 1'b0;
    end else begin
      cs_prev_reg <= CS;
    end
  end

  // A CPU control write outranks the sequencer's own end-of-frame clear
  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      ena_reg  <= 1'b0;
      loop_reg <= 1'b0;
    end else if (ctrl_wr) begin
      ena_reg  <= DIN[BIT_ENA];
      loop_reg <= DIN[BIT_LOOP];
    end else if (ena_clr) begin
      ena_reg  <= 1'b0;
    end
  end

  // Index 0 = frame start, index 1 = frame end
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_frame
      localparam logic [5:0] BASE = (gi == 0) ? OFS_START_HI : OFS_END_HI;
      logic [FIELD_W-1:0] field_reg;

      always_ff @(posedge clk32 or posedge res) begin
        if (res) begin
          field_reg <= '0;
        end else if (wr_stb) begin
          if (A == BASE) begin
            field_reg[20:15] <= DIN[5:0];
          end else if (A == BASE + 6'd1) begin
            field_reg[14:7] <= DIN[7:0];
          end else if (A == BASE + 6'd2) begin
            field_reg[6:0] <= DIN[7:1];
          end
        end
      end

      assign frame_word[gi] = field_reg;
    end
  endgenerate

  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      cur_end_reg <= '0;
    end else if (shadow_load) begin
      cur_end_reg <= frame_word[1];
    end
  end

  assign loop       = loop_reg;
  assign start_word = ADDR_W'(frame_word[0]);
  assign end_word   = ADDR_W'(frame_word[1]);
  assign cur_end    = ADDR_W'(cur_end_reg);

  always_comb begin
    rd_byte = 8'h00;
    case (A)
      OFS_CTRL:      rd_byte = {6'b000000, loop_reg, ena_reg};
      OFS_START_HI:  rd_byte = field_byte(frame_word[0], 2'd0);
      OFS_START_MID: rd_byte = field_byte(frame_word[0], 2'd1);
      OFS_START_LO:  rd_byte = field_byte(frame_word[0], 2'd2);
      OFS_CNT_HI:    rd_byte = field_byte(counter, 2'd0);
      OFS_CNT_MID:   rd_byte = field_byte(counter, 2'd1);
      OFS_CNT_LO:    rd_byte = field_byte(counter, 2'd2);
      OFS_END_HI:    rd_byte = field_byte(frame_word[1], 2'd0);
      OFS_END_MID:   rd_byte = field_byte(frame_word[1], 2'd1);
      OFS_END_LO:    rd_byte = field_byte(frame_word[1], 2'd2);
      default:       rd_byte = 8'h00;
    endcase
    DOUT = CS ? {8'h00, rd_byte} : 16'h0000;
  end

endmodule

// File: rtl/gstdmasnd.sv
// STE DMA sound frame sequencer: walks the frame word by word, fetching on
// MCU sound slots while the shifter FIFO has room, and flags frame ends.
module gstdmasnd
  import gstdmasnd_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LOAD_LOW = 4
) (
  input  logic              clk32,
  input  logic              res,
  input  logic              CS,
  input  logic [5:0]        A,
  input  logic              RW,
  input  logic [15:0]       DIN,
  output logic [15:0]       DOUT,
  input  logic              SREQ,
  input  logic              SLOT,
  output logic [ADDR_W-1:0] SADDR,
  output logic              SLOAD_N,
  output logic              SACTIVE,
  output logic              SFRAME_END
);

  localparam int CW = $clog2(LOAD_LOW) + 1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] counter_reg, counter_next, counter_inc;
  logic [CW-1:0]     load_cnt_reg, load_cnt_next;
  logic              sframe_end_reg, frame_end;
  logic              ctrl_wr, loop, shadow_load, ena_clr;
  logic [ADDR_W-1:0] start_word, end_word, cur_end;

  gstdmasnd_regs #(
    .ADDR_W (ADDR_W)
  ) u_regs (
    .clk32       (clk32),
    .res         (res),
    .CS          (CS),
    .A           (A),
    .RW          (RW),
    .DIN         (DIN),
    .DOUT        (DOUT),
    .counter     (counter_reg[FIELD_W-1:0]),
    .shadow_load (shadow_load),
    .ena_clr     (ena_clr),
    .ctrl_wr     (ctrl_wr),
    .loop        (loop),
    .start_word  (start_word),
    .end_word    (end_word),
    .cur_end     (cur_end)
  );

  always_comb begin
    state_next    = state_reg;
    counter_next  = counter_reg;
    load_cnt_next = load_cnt_reg;
    frame_end     = 1'b0;
    ena_clr       = 1'b0;
    shadow_load   = 1'b0;
    counter_inc   = counter_reg + ADDR_W'(1);

    case (state_reg)
      S_IDLE: begin
      end
      S_ARM: begin
        shadow_load  = 1'b1;
        counter_next = start_word;
        if (start_word >= end_word) begin
          frame_end = 1'b1;
          if (!loop) begin
            state_next = S_IDLE;
            ena_clr    = 1'b1;
          end
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (SLOT && SREQ) begin
          state_next    = S_LOAD;
          load_cnt_next = '0;
        end
      end
      S_LOAD: begin
        if (load_cnt_reg == CW'(LOAD_LOW - 1)) begin
          state_next = S_STEP;
        end else begin
          load_cnt_next = load_cnt_reg + CW'(1);
        end
      end
      S_STEP: begin
        counter_next = counter_inc;
        if (counter_inc == cur_end) begin
          frame_end = 1'b1;
          if (loop) begin
            state_next = S_ARM;
          end else begin
            state_next = S_IDLE;
            ena_clr    = 1'b1;
          end
        end else begin
          state_next = S_WAIT;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // CPU control write overrides: ENA=0 aborts silently, ENA=1 only starts a stopped sequencer
    if (ctrl_wr) begin
      if (!DIN[BIT_ENA]) begin
        if (state_reg != S_IDLE) begin
          state_next   = S_IDLE;
          counter_next = counter_reg;
          frame_end    = 1'b0;
        end
      end else if (state_next == S_IDLE) begin
        state_next = S_ARM;
      end
    end
  end

  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      state_reg      <= S_IDLE;
      counter_reg    <= '0;
      load_cnt_reg   <= '0;
      sframe_end_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      counter_reg    <= counter_next;
      load_cnt_reg   <= load_cnt_next;
      sframe_end_reg <= frame_end;
    end
  end

  assign SADDR      = counter_reg;
  assign SLOAD_N    = (state_reg != S_LOAD);
  assign SACTIVE    = (state_reg != S_IDLE);
  assign SFRAME_END = sframe_end_reg;

endmodule

// File: tb/tb_gstdmasnd.sv
// Bench for gstdmasnd: directed frames plus randomized SLOT/SREQ traffic checked
// against a frame-level model (expected fetch list = start .. end-1 words).
module tb_gstdmasnd;

  localparam int ADDR_W   = 23;
  localparam int LOAD_LOW = 4;

  logic              clk32 = 1'b0;
  logic              res   = 1'b1;
  logic              CS    = 1'b0;
  logic [5:0]        A     = 6'h00;
  logic              RW    = 1'b1;
  logic [15:0]       DIN   = 16'h0000;
  logic [15:0]       DOUT;
  logic              SREQ  = 1'b0;
  logic              SLOT  = 1'b0;
  logic [ADDR_W-1:0] SADDR;
  logic              SLOAD_N, SACTIVE, SFRAME_END;

  always #5 clk32 = ~clk32;

  gstdmasnd #(
    .ADDR_W   (ADDR_W),
    .LOAD_LOW (LOAD_LOW)
  ) dut (
    .clk32      (clk32),
    .res        (res),
    .CS         (CS),
    .A          (A),
    .RW         (RW),
    .DIN        (DIN),
    .DOUT       (DOUT),
    .SREQ       (SREQ),
    .SLOT       (SLOT),
    .SADDR      (SADDR),
    .SLOAD_N    (SLOAD_N),
    .SACTIVE    (SACTIVE),
    .SFRAME_END (SFRAME_END)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus environment: 0=off, 1=periodic/always, 2=random
  int slot_mode = 0;
  int sreq_mode = 0;
  int cyc       = 0;

  initial begin
    forever begin
      @(negedge clk32);
      cyc++;
      case (slot_mode)
        1:       SLOT = (cyc % 8 == 0);
        2:       SLOT = ($urandom_range(0, 3) == 0);
        default: SLOT = 1'b0;
      endcase
      case (sreq_mode)
        1:       SREQ = 1'b1;
        2:       SREQ = ($urandom_range(0, 2) != 0);
        default: SREQ = 1'b0;
      endcase
    end
  end

  // Fetch monitor: one record per SLOAD_N low episode
  logic              in_fetch = 1'b0;
  logic [ADDR_W-1:0] fa       = '0;
  int                flen     = 0;
  logic [ADDR_W-1:0] fetch_addr_q[$];
  int                fetch_len_q[$];
  int                frame_end_cnt = 0;
  int                saddr_glitch  = 0;

  initial begin
    forever begin
      @(negedge clk32);
      if (res) begin
        in_fetch = 1'b0;
      end else begin
        if (!SLOAD_N) begin
          if (!in_fetch) begin
            in_fetch = 1'b1;
            fa       = SADDR;
            flen     = 1;
          end else begin
            flen++;
            if (SADDR != fa) saddr_glitch++;
          end
        end else if (in_fetch) begin
          in_fetch = 1'b0;
          fetch_addr_q.push_back(fa);
          fetch_len_q.push_back(flen);
          $display("fetch addr=%06h len=%0d", fa, flen);
        end
        if (SFRAME_END) begin
          frame_end_cnt++;
          $display("frame end at cycle %0d", cyc);
        end
      end
    end
  end

  task automatic wr(input logic [5:0] off, input logic [7:0] d);
    @(negedge clk32);
    A   = off;
    DIN = {8'h00, d};
    RW  = 1'b0;
    CS  = 1'b1;
    @(negedge clk32);
    CS  = 1'b0;
    RW  = 1'b1;
  endtask

  task automatic rd(input logic [5:0] off, output logic [7:0] d);
    A  = off;
    RW = 1'b1;
    CS = 1'b1;
    #1;
    d  = DOUT[7:0];
    CS = 1'b0;
  endtask

  task automatic set_frame(input logic [23:0] sb, input logic [23:0] eb);
    wr(6'h01, {2'b00, sb[21:16]});
    wr(6'h02, sb[15:8]);
    wr(6'h03, sb[7:0]);
    wr(6'h07, {2'b00, eb[21:16]});
    wr(6'h08, eb[15:8]);
    wr(6'h09, eb[7:0]);
  endtask

  task automatic read_cnt(output logic [23:0] b);
    logic [7:0] h, m, l;
    rd(6'h04, h);
    rd(6'h05, m);
    rd(6'h06, l);
    b = {h, m, l};
  endtask

  task automatic clear_mon();
    fetch_addr_q.delete();
    fetch_len_q.delete();
    frame_end_cnt = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && SACTIVE; i++) @(negedge clk32);
    check(tag, 32'(SACTIVE), 32'h0);
  endtask

  // Model check: fetches must be consecutive words from first_word, LOAD_LOW long each
  task automatic check_fetches(input string tag, input int first_idx, input logic [ADDR_W-1:0] first_word, input int n);
    for (int k = 0; k < n && (first_idx + k) < fetch_addr_q.size(); k++) begin
      check({tag, "_addr"}, 32'(fetch_addr_q[first_idx + k]), 32'(first_word + ADDR_W'(k)));
      check({tag, "_len"}, 32'(fetch_len_q[first_idx + k]), 32'(LOAD_LOW));
    end
  endtask

  initial begin
    logic [7:0]  d;
    logic [23:0] cb;
    logic [20:0] sw;
    int          len;

    // Reset state
    repeat (3) @(negedge clk32);
    check("rst_sload_n", 32'(SLOAD_N), 32'h1);
    check("rst_sactive", 32'(SACTIVE), 32'h0);
    check("rst_frame_end", 32'(SFRAME_END), 32'h0);
    check("rst_saddr", 32'(SADDR), 32'h0);
    rd(6'h00, d); check("rst_ctrl", 32'(d), 32'h0);
    rd(6'h09, d); check("rst_end_lo", 32'(d), 32'h0);
    check("dout_unselected", 32'(DOUT), 32'h0);
    res = 1'b0;
    @(negedge clk32);

    // Single frame, four words
    clear_mon();
    slot_mode = 1; sreq_mode = 1;
    set_frame(24'h010000, 24'h010008);
    rd(6'h03, d); check("a_start_lo", 32'(d), 32'h0);
    rd(6'h01, d); check("a_start_hi", 32'(d), 32'h01);
    wr(6'h00, 8'h01);
    wait_idle("a_done", 400);
    check("a_nfetch", 32'(fetch_addr_q.size()), 32'd4);
    check_fetches("a", 0, 23'h008000, 4);
    check("a_frame_end", 32'(frame_end_cnt), 32'd1);
    rd(6'h00, d); check("a_ctrl", 32'(d), 32'h0);
    read_cnt(cb); check("a_counter", 32'(cb), 32'h010008);

    // Looping frame with end shortened mid-frame
    clear_mon();
    wr(6'h00, 8'h03);
    for (int i = 0; i < 400 && fetch_addr_q.size() < 2; i++) @(negedge clk32);
    wr(6'h09, 8'h04);
    for (int i = 0; i < 800 && frame_end_cnt < 2; i++) @(negedge clk32);
    check("b_frame_end", 32'(frame_end_cnt), 32'd2);
    check("b_sactive", 32'(SACTIVE), 32'h1);
    rd(6'h00, d); check("b_ctrl", 32'(d), 32'h3);
    wr(6'h00, 8'h00);
    @(negedge clk32);
    check("b_stopped", 32'(SACTIVE), 32'h0);
    check("b_nfetch", 32'(fetch_addr_q.size() >= 6), 32'h1);
    check_fetches("b1", 0, 23'h008000, 4);
    check_fetches("b2", 4, 23'h008000, 2);

    // SREQ held low: slots must be ignored
    clear_mon();
    sreq_mode = 0;
    set_frame(24'h010000, 24'h010008);
    wr(6'h00, 8'h01);
    repeat (50) @(negedge clk32);
    check("c_nofetch", 32'(fetch_addr_q.size()), 32'd0);
    read_cnt(cb); check("c_counter0", 32'(cb), 32'h010000);
    sreq_mode = 1;
    for (int i = 0; i < 40 && fetch_addr_q.size() < 1; i++) @(negedge clk32);
    check("c_fetch", 32'(fetch_addr_q.size()), 32'd1);
    repeat (3) @(negedge clk32);
    read_cnt(cb); check("c_counter1", 32'(cb), 32'h010002);
    wr(6'h00, 8'h00);
    repeat (2) @(negedge clk32);
    check("c_stopped", 32'(SACTIVE), 32'h0);
    check("c_frame_end", 32'(frame_end_cnt), 32'd0);

    // Empty frame
    clear_mon();
    set_frame(24'h020000, 24'h020000);
    wr(6'h00, 8'h01);
    repeat (10) @(negedge clk32);
    check("d_frame_end", 32'(frame_end_cnt), 32'd1);
    check("d_nfetch", 32'(fetch_addr_q.size()), 32'd0);
    check("d_sactive", 32'(SACTIVE), 32'h0);
    rd(6'h00, d); check("d_ctrl", 32'(d), 32'h0);

    // Abort in WAIT after two fetches
    clear_mon();
    set_frame(24'h010000, 24'h010010);
    wr(6'h00, 8'h01);
    for (int i = 0; i < 400 && SADDR != 23'h008002; i++) @(negedge clk32);
    wr(6'h00, 8'h00);
    repeat (40) @(negedge clk32);
    check("e_nfetch", 32'(fetch_addr_q.size()), 32'd2);
    check("e_frame_end", 32'(frame_end_cnt), 32'd0);
    check("e_sactive", 32'(SACTIVE), 32'h0);
    read_cnt(cb); check("e_counter", 32'(cb), 32'h010004);

    // Random frames under random SLOT/SREQ traffic
    for (int it = 0; it < 6; it++) begin
      clear_mon();
      slot_mode = 2; sreq_mode = 2;
      sw  = 21'($urandom_range(0, 32'h1FFFF0));
      len = int'($urandom_range(1, 5));
      set_frame({2'b00, sw, 1'b0}, {2'b00, sw + 21'(len), 1'b0});
      wr(6'h00, 8'h01);
      wait_idle("r_done", 3000);
      check("r_nfetch", 32'(fetch_addr_q.size()), 32'(len));
      check_fetches("r", 0, ADDR_W'(sw), len);
      check("r_frame_end", 32'(frame_end_cnt), 32'd1);
      read_cnt(cb); check("r_counter", 32'(cb), 32'({2'b00, sw + 21'(len), 1'b0}));
    end

    // Reset while SLOAD_N is low
    slot_mode = 1; sreq_mode = 1;
    set_frame(24'h010000, 24'h010008);
    wr(6'h00, 8'h01);
    for (int i = 0; i < 100 && SLOAD_N; i++) @(negedge clk32);
    check("g_in_load", 32'(SLOAD_N), 32'h0);
    #2 res = 1'b1;
    #1;
    check("g_sload_n", 32'(SLOAD_N), 32'h1);
    check("g_sactive", 32'(SACTIVE), 32'h0);
    check("g_saddr", 32'(SADDR), 32'h0);
    check("g_frame_end", 32'(SFRAME_END), 32'h0);
    rd(6'h00, d); check("g_ctrl", 32'(d), 32'h0);
    rd(6'h03, d); check("g_start_lo", 32'(d), 32'h0);
    rd(6'h06, d); check("g_cnt_lo", 32'(d), 32'h0);
    rd(6'h08, d); check("g_end_mid", 32'(d), 32'h0);
    @(negedge clk32);
    res = 1'b0;
    repeat (3) @(negedge clk32);
    check("g_after", 32'(SACTIVE), 32'h0);

    check("saddr_stable", 32'(saddr_glitch), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
